seq_binary_multiplier: RTL and testbench
========================================

SEQ_BINARY_MULTIPLIER -- requirements
Module: seq_binary_multiplier

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on rising clk; accepted only when busy=0.
REQ-005 multiplicand  input  WIDTH  unsigned operand B; sampled on the accepting edge only.
REQ-006 multiplier  input  WIDTH  unsigned operand Q; sampled on the accepting edge only.
REQ-007 product  output  2*WIDTH  registered unsigned result; holds its value until the next completion.
REQ-008 busy  output  1  registered; high while a multiplication is in progress.
REQ-009 done  output  1  registered; one-cycle pulse when product is updated.

Function
REQ-010 Algorithm: add-and-shift. Internal registers are B[WIDTH], Q[WIDTH], A[WIDTH], carry C[1], and down-counter P[ceil(log2(WIDTH+1))].
REQ-011 The A+B adder SHALL be a WIDTH-bit ripple chain of full_adder cells; carry-in is 0 and carry-out goes to C.
REQ-012 FSM states: IDLE, ADD, SHIFT; reset state is IDLE.
REQ-013 IDLE with start=1, accepting edge k:
- load B, Q;
- clear A and C;
- set P=WIDTH;
- busy goes to 1;
- next state is ADD.
REQ-014 ADD: if Q[0]=1, then {C,A} <= A+B, else A and C are unchanged; P <= P-1; next state is SHIFT.
REQ-015 SHIFT: {C,A,Q} <= {1'b0,C,A,Q} >> 1 (logical right shift by one); if P==0, go to IDLE, else go to ADD.
REQ-016 On SHIFT with P==0:
- product <= {A,Q} after the shift;
- done goes to 1 for exactly one cycle;
- busy goes to 0.
REQ-017 Latency: done=1 and product valid in the cycle following edge k+2*WIDTH (8 cycles for WIDTH=4).
REQ-018 start while busy=1 SHALL be ignored; operands and state are unaffected and no error is flagged.
REQ-019 start in the same cycle as done=1 (state IDLE) SHALL be accepted, giving back-to-back operation with no dead cycle.
REQ-020 product SHALL be exact for all operand pairs, max (2^WIDTH-1)^2, with no overflow possible in 2*WIDTH bits.
REQ-021 done and busy SHALL never be high in the same cycle.

Reset
REQ-022 rst_n=0 asynchronously forces:
- state IDLE;
- product=0, busy=0, done=0;
- A, B, Q, C, P = 0.
REQ-023 Reset mid-operation aborts the operation; no done pulse follows, and product reads 0.
REQ-024 After rst_n deasserts, the first rising edge with start=1 is accepted.

Configuration
REQ-025 Macro MULT_EARLY_ZERO_EN.
- Defined: if multiplicand==0 or multiplier==0 on the accepting edge, then product <= 0 and done=1 in the next cycle; busy stays 0, the FSM stays in IDLE, and latency is 1 cycle.
- Undefined: zero operands take the full 2*WIDTH-cycle path; the result is identical and only latency differs.

Verification
REQ-026 WIDTH=4, start with 13 x 11 -> busy=1 for 8 cycles, then done=1 one cycle later with product=143 (0x8F).
REQ-027 15 x 15 -> product=225 (0xE1); a second start with 1 x 1 in the done cycle -> product=1 exactly 8 cycles after it.
REQ-028 0 x 9 -> product=0; done after 1 cycle with MULT_EARLY_ZERO_EN defined, after 8 cycles without it.
REQ-029 start with 7 x 6, then another start with 3 x 3 at cycle 3 while busy -> second start ignored; product=42, and only one done pulse.
REQ-030 rst_n=0 asynchronously at cycle 4 of 9 x 9 -> busy, done and product read 0 immediately; no done pulse follows; the next start with 2 x 3 -> product=6.
REQ-031 Exhaustive 16x16 operand sweep checked against a reference product; done and busy never high together.

Source files
------------

// File: rtl/seq_binary_multiplier_if.sv
// Handshake/operand bundle for seq_binary_multiplier.
// master: request side (drives start and operands); slave: the multiplier.
interface seq_binary_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output product,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_binary_multiplier.sv
// Sequential add-and-shift unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Optional feature macro: MULT_EARLY_ZERO_EN -- when defined, a request with
// a zero operand completes from IDLE in one cycle without entering ADD/SHIFT.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; done may be pulsing from the last result
// S_ADD   | conditionally add B into A (when Q[0]=1), decrement P
// S_SHIFT | shift {C,A,Q} right by one; finish when P has reached 0

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_binary_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_binary_multiplier_if.slave  bus
);

  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_a;
  logic             reg_c;
  logic [PW-1:0]    cnt_p;

  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic load;
  logic add_step;
  logic shift_step;
  logic finish;
  logic zero_finish;

  // Ripple-carry A+B adder built from full_adder cells; carry-out feeds C.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a    (reg_a[i]),
      .b    (reg_b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes; start is only looked at in S_IDLE,
  // which is what makes a start during an operation harmless.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    add_step    = 1'b0;
    shift_step  = 1'b0;
    finish      = 1'b0;
    zero_finish = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef MULT_EARLY_ZERO_EN
          if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
            zero_finish = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = S_ADD;
          end
`else
          load       = 1'b1;
          state_next = S_ADD;
`endif
        end
      end
      S_ADD: begin
        add_step   = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shift_step = 1'b1;
        if (cnt_p == '0) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_ADD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_b       <= '0;
      reg_q       <= '0;
      reg_a       <= '0;
      reg_c       <= 1'b0;
      cnt_p       <= '0;
      bus.product <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= finish | zero_finish;
      if (load) begin
        reg_b    <= bus.multiplicand;
        reg_q    <= bus.multiplier;
        reg_a    <= '0;
        reg_c    <= 1'b0;
        cnt_p    <= PW'(WIDTH);
        bus.busy <= 1'b1;
      end
      if (add_step) begin
        if (reg_q[0]) begin
          reg_a <= sum;
          reg_c <= carry[WIDTH];
        end
        cnt_p <= cnt_p - 1'b1;
      end
      if (shift_step) begin
        reg_c <= 1'b0;
        reg_a <= {reg_c, reg_a[WIDTH-1:1]};
        reg_q <= {reg_a[0], reg_q[WIDTH-1:1]};
        if (finish) begin
          // {A,Q} as it will look after this shift.
          bus.product <= {reg_c, reg_a, reg_q[WIDTH-1:1]};
          bus.busy    <= 1'b0;
        end
      end
      if (zero_finish) begin
        bus.product <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_binary_multiplier.sv
// Self-checking bench for seq_binary_multiplier, WIDTH=4.
module tb_seq_binary_multiplier;

  localparam int W = 4;
`ifdef MULT_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;

  seq_binary_multiplier_if #(.WIDTH(W)) bus ();

  seq_binary_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation started on the next negedge. lat counts rising edges after
  // the accepting edge until done is seen; bcnt counts busy cycles; ovl counts
  // cycles with busy and done together; dn_after is done one cycle after done.
  task automatic do_op(input logic [W-1:0] b, input logic [W-1:0] q,
                       output logic [2*W-1:0] prod, output int lat,
                       output int bcnt, output int ovl, output int dn_after);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = b;
    bus.multiplier = q;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = 0; ovl = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy && bus.done) ovl++;
    prod = bus.product;
    @(posedge clk); #1;
    dn_after = int'(bus.done);
  endtask

  function automatic int exp_lat(input logic [W-1:0] b, input logic [W-1:0] q);
    return (EARLY && (b == 0 || q == 0)) ? 0 : 2 * W;
  endfunction

  initial begin
    logic [2*W-1:0] prod;
    int lat, bcnt, ovl, dn_after, n, dcnt;
    int sweep_err, sweep_ovl;

    vecs[0] = '{4'd13, 4'd11, 8'd143};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd9,  8'd0};
    vecs[3] = '{4'd9,  4'd0,  8'd0};
    vecs[4] = '{4'd1,  4'd1,  8'd1};
    vecs[5] = '{4'd15, 4'd1,  8'd15};
    vecs[6] = '{4'd2,  4'd3,  8'd6};
    vecs[7] = '{4'd7,  4'd6,  8'd42};
    vecs[8] = '{4'd8,  4'd8,  8'd64};
    vecs[9] = '{4'd0,  4'd0,  8'd0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", int'(bus.product), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].b, vecs[i].q, prod, lat, bcnt, ovl, dn_after);
      check($sformatf("vec%0d_product", i), int'(prod), int'(vecs[i].prod));
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b, vecs[i].q));
      check($sformatf("vec%0d_busy_cycles", i), bcnt, exp_lat(vecs[i].b, vecs[i].q));
      check($sformatf("vec%0d_overlap", i), ovl, 0);
      check($sformatf("vec%0d_done_width", i), dn_after, 0);
    end

    // Back-to-back: second start issued in the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'd15; bus.multiplier = 4'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b_first_product", int'(bus.product), 225);
    bus.start = 1'b1; bus.multiplicand = 4'd1; bus.multiplier = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy_no_gap", int'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b_second_latency", n, 2 * W);
    check("b2b_second_product", int'(bus.product), 1);

    // Start while busy is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'd7; bus.multiplier = 4'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcnt = 0; n = 0;
    @(posedge clk); #1; n++;
    bus.start = 1'b1; bus.multiplicand = 4'd3; bus.multiplier = 4'd3;
    @(posedge clk); #1; n++;
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin
        dcnt++;
        check("ignore_done_cycle", n, 2 * W);
      end
      @(posedge clk); #1; n++;
    end
    check("ignore_done_count", dcnt, 1);
    check("ignore_product", int'(bus.product), 42);

    // Asynchronous reset in the middle of 9 x 9.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'd9; bus.multiplier = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_product", int'(bus.product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("arst_no_done", dcnt, 0);
    check("arst_product_held", int'(bus.product), 0);
    do_op(4'd2, 4'd3, prod, lat, bcnt, ovl, dn_after);
    check("arst_next_product", int'(prod), 6);
    check("arst_next_latency", lat, 2 * W);

    // Exhaustive sweep against a reference product.
    sweep_err = 0; sweep_ovl = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(W'(a), W'(b), prod, lat, bcnt, ovl, dn_after);
        checks++;
        if (int'(prod) != a * b || lat != exp_lat(W'(a), W'(b))) begin
          errors++;
          sweep_err++;
          $display("FAIL sweep_%0dx%0d: got %0d lat %0d expected %0d lat %0d",
                   a, b, prod, lat, a * b, exp_lat(W'(a), W'(b)));
        end
        sweep_ovl += ovl;
      end
    end
    check("sweep_overlap", sweep_ovl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
